dispatch_arbiter: RTL and testbench
===================================

Name: dispatch_arbiter

Overview:
Round-robin scheduler that shares one downstream multiply/accumulate channel between NUM_REQ dispatcher outputs. Each dispatcher packet (activation, weight, zero-info) enters a small per-requester FIFO inside this block, so no combinational valid/avail loop forms. One packet per cycle is forwarded, tagged with the requester id. Configured beat counters per requester raise done when every dispatcher has delivered its expected packet count.

Parameters:
NUM_REQ, 4, number of dispatcher requesters
LOG_NUM_REQ, 2, bits of requester id (clog2 NUM_REQ)
PACKET_WIDTH, 20, packet width (2*DATA_WIDTH + GROUP_SIZE for default 8-bit data, group 4)
LOG_MAX_BEATS, 16, width of per-requester beat counters
FIFO_SLOTS, 4, depth of each per-requester FIFO (fixed at 4; LOG 2)

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-low
configure  in  1  one-cycle pulse; loads num_beats into every requester counter
num_beats  in  LOG_MAX_BEATS  packets expected from each requester
data_in  in  NUM_REQ*PACKET_WIDTH  packed packets; requester i at [i*PACKET_WIDTH +: PACKET_WIDTH]
valid_in  in  NUM_REQ  per-requester write strobe
avail_out  out  NUM_REQ  per-requester space available
data_out  out  PACKET_WIDTH  forwarded packet
id_out  out  LOG_NUM_REQ  index of requester that produced data_out
valid_out  out  1  data_out/id_out valid (one-cycle strobe per packet)
avail_in  in  1  downstream can take one more packet
done  out  1  all counters zero after a configure (sticky until next configure)
overflow  out  1  sticky error: write attempted into a full FIFO

Behaviour:
- Reset (rst=0 at clk edge): FIFOs empty, occupancy 0, rr pointer = NUM_REQ-1 (so requester 0 wins first), counters 0, enabled 0. Outputs: data_out 0, id_out 0, valid_out 0, done 0, overflow 0. avail_out all 1 (combinational from occupancy). Reset mid-operation discards all buffered packets.
- Write side, per requester i: valid_in[i]=1 writes data_in slice into FIFO i. avail_out[i] = (occ_i <= FIFO_SLOTS-2). The free slot left when avail drops absorbs one in-flight write from a source that sampled avail a cycle late. If valid_in[i]=1 and occ_i=FIFO_SLOTS and no pop that cycle, the packet is dropped and overflow set (cleared only by reset). Write into a full FIFO with a simultaneous pop of the same FIFO is legal and accepted.
- Arbitration (combinational): candidates = FIFOs with occ>0. Grant = first candidate searching ptr+1, ptr+2, … wrapping modulo NUM_REQ. Pop occurs when avail_in=1 and at least one candidate exists. On pop, ptr <= granted index; otherwise ptr unchanged.
- Output: registered. On pop at edge N, data_out/id_out load the granted head and valid_out=1 for the cycle after edge N (1-cycle latency). With no pop, valid_out=0 and data_out/id_out hold their last values. The downstream must accept every valid_out; it keeps avail_in low when it cannot take one more packet.
- Counters: configure loads cnt_i = num_beats for all i, enabled <= 1 and done <= 0. Each pop from requester i decrements cnt_i, saturating at 0; extra packets are still forwarded. done <= 1 when enabled and every cnt_i is 0 after the update; enabled <= 0 at the same edge. configure with num_beats=0 gives done=1 on the next cycle.
- Configure in the same cycle as a pop: the packet is forwarded normally, counters take num_beats, and that pop is not counted. Configure while busy reloads counters and keeps FIFO contents.
- Simultaneous write and pop on the same FIFO: occupancy unchanged; data ordering preserved (FIFO order per requester always kept).

Test Plan:
- Reset then idle: rst low 2 cycles -> avail_out=4'b1111, valid_out=0, done=0, overflow=0.
- All 4 requesters write 1 packet each (data 0x10,0x20,0x30,0x40) same cycle, avail_in=1 -> valid_out on 4 consecutive cycles, id_out 0,1,2,3, data in that order.
- Fairness: requesters 1 and 3 each continuously valid, avail_in=1 -> id_out alternates 1,3,1,3; requester 3 never starved.
- Backpressure: avail_in=0, requester 2 writes 3 packets -> avail_out[2] falls after 3rd write (occ=3). A 4th write is accepted with no overflow. A 5th write sets overflow=1. Raising avail_in drains 4 packets in order.
- configure num_beats=2, each requester sends 2 packets -> done rises one cycle after the 8th pop. A 9th packet is forwarded and done stays 1.
- configure asserted in the same cycle as a pop with num_beats=1 -> counters=1 (pop not counted). configure num_beats=0 -> done=1 next cycle.

Source files
------------

// File: rtl/dispatch_arbiter.sv
// dispatch_arbiter: round-robin scheduler sharing one MAC channel between
// NUM_REQ dispatchers. Each requester feeds a 4-slot FIFO. One packet per
// cycle is forwarded with its requester id. Per-requester beat counters
// raise done once every dispatcher has delivered its configured count.
module dispatch_arbiter #(
  parameter int NUM_REQ       = 4,
  parameter int LOG_NUM_REQ   = 2,
  parameter int PACKET_WIDTH  = 20,
  parameter int LOG_MAX_BEATS = 16,
  parameter int FIFO_SLOTS    = 4
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            configure,
  input  logic [LOG_MAX_BEATS-1:0]        num_beats,
  input  logic [NUM_REQ*PACKET_WIDTH-1:0] data_in,
  input  logic [NUM_REQ-1:0]              valid_in,
  output logic [NUM_REQ-1:0]              avail_out,
  output logic [PACKET_WIDTH-1:0]         data_out,
  output logic [LOG_NUM_REQ-1:0]          id_out,
  output logic                            valid_out,
  input  logic                            avail_in,
  output logic                            done,
  output logic                            overflow
);

  // FIFO depth is fixed at 4, so slot pointers are 2 bits and occupancy 3 bits
  localparam int SLOT_W = 2;
  localparam int OCC_W  = 3;

  logic [PACKET_WIDTH-1:0]                mem_q [NUM_REQ][FIFO_SLOTS];
  logic [NUM_REQ-1:0][SLOT_W-1:0]         wrPtr_q, rdPtr_q;
  logic [NUM_REQ-1:0][OCC_W-1:0]          occ_q, occ_d;
  logic [LOG_NUM_REQ-1:0]                 rrPtr_q, rrPtr_d;
  logic [NUM_REQ-1:0][LOG_MAX_BEATS-1:0]  cnt_q, cnt_d;
  logic                                   enabled_q, enabled_d;
  logic                                   done_q, done_d;
  logic                                   overflow_q, overflow_d;
  logic [PACKET_WIDTH-1:0]                dataOut_q, dataOut_d;
  logic [LOG_NUM_REQ-1:0]                 idOut_q, idOut_d;
  logic                                   validOut_q;

  logic                                   found;
  logic                                   pop;
  logic [LOG_NUM_REQ-1:0]                 grantIdx;
  logic [NUM_REQ-1:0]                     popSel;
  logic [NUM_REQ-1:0]                     pushEn;
  logic [NUM_REQ-1:0]                     ovfSet;
  logic                                   allZero;

  // Round-robin search starting just after the last granted requester
  always_comb begin
    int idx;
    idx      = 0;
    found    = 1'b0;
    grantIdx = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = (int'(rrPtr_q) + k) % NUM_REQ;
      if (!found && (occ_q[idx] != '0)) begin
        found    = 1'b1;
        grantIdx = LOG_NUM_REQ'(idx);
      end
    end
    pop = avail_in && found;
  end

  // Per-requester push/pop decisions, occupancy update and space flags
  always_comb begin
    popSel    = '0;
    pushEn    = '0;
    ovfSet    = '0;
    occ_d     = occ_q;
    avail_out = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      popSel[i]    = pop && (grantIdx == LOG_NUM_REQ'(i));
      pushEn[i]    = valid_in[i] && ((occ_q[i] != OCC_W'(FIFO_SLOTS)) || popSel[i]);
      ovfSet[i]    = valid_in[i] && (occ_q[i] == OCC_W'(FIFO_SLOTS)) && !popSel[i];
      occ_d[i]     = occ_q[i] + OCC_W'(pushEn[i]) - OCC_W'(popSel[i]);
      avail_out[i] = (occ_q[i] <= OCC_W'(FIFO_SLOTS - 2));
    end
  end

  // Packet storage; contents need no reset because occupancy gates every read
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pushEn[i]) begin
        mem_q[i][wrPtr_q[i]] <= data_in[i*PACKET_WIDTH +: PACKET_WIDTH];
      end
    end
  end

  // FIFO pointers and occupancy; reset discards anything buffered
  always_ff @(posedge clk) begin
    if (!rst) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      occ_q   <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (pushEn[i]) wrPtr_q[i] <= wrPtr_q[i] + 1'b1;
        if (popSel[i]) rdPtr_q[i] <= rdPtr_q[i] + 1'b1;
      end
      occ_q <= occ_d;
    end
  end

  // Next output packet, rr pointer and beat counter bookkeeping
  always_comb begin
    rrPtr_d    = rrPtr_q;
    dataOut_d  = dataOut_q;
    idOut_d    = idOut_q;
    cnt_d      = cnt_q;
    enabled_d  = enabled_q;
    done_d     = done_q;
    overflow_d = overflow_q | (|ovfSet);
    allZero    = 1'b1;
    if (pop) begin
      rrPtr_d   = grantIdx;
      dataOut_d = mem_q[grantIdx][rdPtr_q[grantIdx]];
      idOut_d   = grantIdx;
    end
    if (configure) begin
      for (int i = 0; i < NUM_REQ; i++) cnt_d[i] = num_beats;
      enabled_d = 1'b1;
      done_d    = 1'b0;
    end else begin
      if (pop && (cnt_q[grantIdx] != '0)) begin
        cnt_d[grantIdx] = cnt_q[grantIdx] - 1'b1;
      end
      for (int i = 0; i < NUM_REQ; i++) begin
        if (cnt_d[i] != '0) allZero = 1'b0;
      end
      if (enabled_q && allZero) begin
        done_d    = 1'b1;
        enabled_d = 1'b0;
      end
    end
  end

  // Control and output registers; rr pointer resets so requester 0 wins first
  always_ff @(posedge clk) begin
    if (!rst) begin
      rrPtr_q    <= LOG_NUM_REQ'(NUM_REQ - 1);
      dataOut_q  <= '0;
      idOut_q    <= '0;
      validOut_q <= 1'b0;
      cnt_q      <= '0;
      enabled_q  <= 1'b0;
      done_q     <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      rrPtr_q    <= rrPtr_d;
      dataOut_q  <= dataOut_d;
      idOut_q    <= idOut_d;
      validOut_q <= pop;
      cnt_q      <= cnt_d;
      enabled_q  <= enabled_d;
      done_q     <= done_d;
      overflow_q <= overflow_d;
    end
  end

  assign data_out  = dataOut_q;
  assign id_out    = idOut_q;
  assign valid_out = validOut_q;
  assign done      = done_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_dispatch_arbiter.sv
// Testbench for dispatch_arbiter: directed phases followed by random traffic,
// checked against a queue-based reference model and an output scoreboard.
module tb_dispatch_arbiter;

  localparam int NR = 4;
  localparam int PW = 20;
  localparam int LB = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic              configure;
  logic [LB-1:0]     num_beats;
  logic [NR*PW-1:0]  data_in;
  logic [NR-1:0]     valid_in;
  logic [NR-1:0]     avail_out;
  logic [PW-1:0]     data_out;
  logic [1:0]        id_out;
  logic              valid_out;
  logic              avail_in;
  logic              done;
  logic              overflow;

  dispatch_arbiter #(
    .NUM_REQ(NR), .LOG_NUM_REQ(2), .PACKET_WIDTH(PW),
    .LOG_MAX_BEATS(LB), .FIFO_SLOTS(4)
  ) dut (
    .clk(clk), .rst(rst), .configure(configure), .num_beats(num_beats),
    .data_in(data_in), .valid_in(valid_in), .avail_out(avail_out),
    .data_out(data_out), .id_out(id_out), .valid_out(valid_out),
    .avail_in(avail_in), .done(done), .overflow(overflow)
  );

  // Free-running clock
  always #5 clk = ~clk;

  // Reference model state: one packet queue per requester plus scoreboard
  logic [PW-1:0]   mq [NR][$];
  logic [PW+1:0]   expQ [$];
  int              mPtr;
  int              mCnt [NR];
  bit              mEn, mDone, mOvf, mValid, mInit;
  int              checks = 0;
  int              failures = 0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [NR-1:0] availMask();
    logic [NR-1:0] m;
    for (int i = 0; i < NR; i++) m[i] = (mq[i].size() <= 2);
    return m;
  endfunction

  function automatic logic [NR*PW-1:0] randData();
    logic [NR*PW-1:0] d;
    d = {16'($urandom()), $urandom(), $urandom()};
    return d;
  endfunction

  // Advance the model by one clock edge using the inputs currently driven
  task automatic modelEdge();
    int g;
    bit allZero;
    g = -1;
    if (!rst) begin
      for (int i = 0; i < NR; i++) begin
        mq[i].delete();
        mCnt[i] = 0;
      end
      expQ.delete();
      mPtr = NR - 1; mEn = 0; mDone = 0; mOvf = 0; mValid = 0;
      return;
    end
    if (avail_in) begin
      for (int k = 1; k <= NR; k++) begin
        int j;
        j = (mPtr + k) % NR;
        if (g < 0 && mq[j].size() > 0) g = j;
      end
    end
    mValid = (g >= 0);
    if (g >= 0) begin
      expQ.push_back({2'(g), mq[g].pop_front()});
      mPtr = g;
    end
    for (int i = 0; i < NR; i++) begin
      if (valid_in[i]) begin
        if (mq[i].size() < 4) mq[i].push_back(data_in[i*PW +: PW]);
        else mOvf = 1;
      end
    end
    if (configure) begin
      for (int i = 0; i < NR; i++) mCnt[i] = int'(num_beats);
      mEn = 1; mDone = 0;
    end else begin
      if (g >= 0 && mCnt[g] > 0) mCnt[g]--;
      allZero = 1;
      for (int i = 0; i < NR; i++) if (mCnt[i] != 0) allZero = 0;
      if (mEn && allZero) begin
        mDone = 1; mEn = 0;
      end
    end
  endtask

  // Drive one cycle of inputs, check status before and after the edge
  task automatic applyStimulus(input bit r, input bit cfg, input logic [LB-1:0] nb,
                               input logic [NR-1:0] vin, input bit ain,
                               input logic [NR*PW-1:0] din);
    rst = r; configure = cfg; num_beats = nb; valid_in = vin;
    avail_in = ain; data_in = din;
    if (mInit) checkOutput("avail_out", 32'(avail_out), 32'(availMask()));
    @(posedge clk);
    modelEdge();
    #1;
    mInit = 1;
    checkOutput("valid_out", 32'(valid_out), 32'(mValid));
    checkOutput("done", 32'(done), 32'(mDone));
    checkOutput("overflow", 32'(overflow), 32'(mOvf));
  endtask

  task automatic idle(input int n, input bit ain);
    for (int c = 0; c < n; c++) applyStimulus(1, 0, '0, '0, ain, randData());
  endtask

  // Scoreboard monitor: every presented packet must match the oldest expected
  initial begin
    logic [PW+1:0] e;
    forever begin
      @(negedge clk);
      if (valid_out === 1'b1) begin
        if (expQ.size() == 0) begin
          checks++;
          failures++;
          $display("[TB] FAIL unexpected_valid actual=id%0d/%0h expected=none t=%0t",
                   id_out, data_out, $time);
        end else begin
          e = expQ.pop_front();
          checkOutput("id_out", 32'(id_out), 32'(e[PW+1:PW]));
          checkOutput("data_out", 32'(data_out), 32'(e[PW-1:0]));
        end
      end
    end
  end

  // Directed phases followed by random traffic
  initial begin
    mInit = 0;
    rst = 0; configure = 0; num_beats = '0; valid_in = '0; avail_in = 0; data_in = '0;

    $display("[TB] reset and idle");
    applyStimulus(0, 0, '0, '0, 0, '0);
    applyStimulus(0, 0, '0, '0, 0, '0);
    checkOutput("reset_data_out", 32'(data_out), 32'h0);
    checkOutput("reset_id_out", 32'(id_out), 32'h0);
    checkOutput("reset_avail_out", 32'(avail_out), 32'hF);
    idle(2, 1);

    $display("[TB] four requesters write together");
    applyStimulus(1, 0, '0, 4'b1111, 1, {20'h40, 20'h30, 20'h20, 20'h10});
    idle(6, 1);

    $display("[TB] fairness between requesters 1 and 3");
    for (int c = 0; c < 12; c++) applyStimulus(1, 0, '0, 4'b1010 & availMask(), 1, randData());
    idle(8, 1);

    $display("[TB] backpressure on requester 2");
    for (int c = 0; c < 5; c++) applyStimulus(1, 0, '0, 4'b0100, 0, randData());
    idle(7, 1);

    $display("[TB] reset with packets buffered");
    applyStimulus(1, 0, '0, 4'b0001, 0, randData());
    applyStimulus(1, 0, '0, 4'b0001, 0, randData());
    applyStimulus(0, 0, '0, '0, 0, randData());
    applyStimulus(0, 0, '0, '0, 0, randData());
    idle(3, 1);

    $display("[TB] beat counting num_beats=2");
    applyStimulus(1, 1, 16'd2, '0, 0, randData());
    applyStimulus(1, 0, '0, 4'b1111, 1, randData());
    applyStimulus(1, 0, '0, 4'b1111, 1, randData());
    idle(10, 1);
    applyStimulus(1, 0, '0, 4'b0001, 1, randData());
    idle(3, 1);

    $display("[TB] configure coinciding with a pop");
    applyStimulus(1, 0, '0, 4'b0001, 0, randData());
    applyStimulus(1, 1, 16'd1, '0, 1, randData());
    idle(4, 1);
    applyStimulus(1, 1, 16'd0, '0, 1, randData());
    idle(2, 1);

    $display("[TB] random traffic");
    for (int c = 0; c < 400; c++) begin
      bit r, cfg, ain;
      logic [NR-1:0] vin;
      r   = ($urandom_range(0, 99) != 0);
      cfg = ($urandom_range(0, 19) == 0);
      ain = ($urandom_range(0, 3) != 0);
      vin = 4'($urandom());
      if ($urandom_range(0, 7) != 0) vin = vin & availMask();
      applyStimulus(r, cfg, 16'($urandom_range(0, 5)), vin, ain, randData());
    end
    idle(12, 1);
    checkOutput("pending_expected", 32'(expQ.size()), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
